// File: rtl/cond_branch_unit.sv
// Branch resolution in ID: holds the architectural NZCV register, evaluates B.cond
// against forwarded EX flags, zero-tests CBZ/CBNZ operands, and counts taken branches.
module cond_branch_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  logic                  ex_set_flags,
   input  logic [3:0]            ex_nzcv,
   input  logic                  id_valid,
   input  logic                  id_stall,
   input  logic                  id_flush,
   input  logic [1:0]            id_br_type,
   input  logic [3:0]            id_cond,
   input  logic [DATA_WIDTH-1:0] id_reg_val,
   output logic [3:0]            nzcv_q,
   output logic                  br_valid_q,
   output logic                  br_taken_q,
   output logic [CNT_WIDTH-1:0]  taken_cnt_q
);

   logic       flag_write;
   logic [3:0] eff_flags;
   logic       flag_n;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;
   logic       cond_pass;
   logic       cond_true;
   logic       issue;
   logic       cnt_max;

   // EX is one instruction older than ID, so its flags take precedence over the register.
   assign flag_write = ex_valid & ex_set_flags;
   assign eff_flags  = flag_write ? ex_nzcv : nzcv_q;
   assign {flag_n, flag_z, flag_c, flag_v} = eff_flags;

   always_comb begin
      cond_pass = 1'b0;
      case (id_cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         default: cond_pass = 1'b1;
      endcase
   end

   always_comb begin
      cond_true = 1'b0;
      case (id_br_type)
         2'b01:   cond_true = cond_pass;
         2'b10:   cond_true = ~(|id_reg_val);
         2'b11:   cond_true = |id_reg_val;
         default: cond_true = 1'b0;
      endcase
   end

   assign issue   = id_valid & ~id_stall & ~id_flush & (id_br_type != 2'b00);
   assign cnt_max = &taken_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         nzcv_q      <= 4'b0000;
         br_valid_q  <= 1'b0;
         br_taken_q  <= 1'b0;
         taken_cnt_q <= '0;
      end else begin
         if (flag_write) begin
            nzcv_q <= ex_nzcv;
         end
         // Decision outputs are single-cycle pulses; nothing is held when no branch issues.
         br_valid_q <= issue;
         br_taken_q <= issue & cond_true;
         if (issue & cond_true & ~cnt_max) begin
            taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Randomized bench for cond_branch_unit: an ARM-condition reference model predicts
// flags, decisions and saturating counts for a 16-bit and a 4-bit counter instance.
module tb_cond_branch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic        ex_set_flags;
   logic [3:0]  ex_nzcv;
   logic        id_valid;
   logic        id_stall;
   logic        id_flush;
   logic [1:0]  id_br_type;
   logic [3:0]  id_cond;
   logic [63:0] id_reg_val;

   logic [3:0]  nzcv_q;
   logic        br_valid_q;
   logic        br_taken_q;
   logic [15:0] taken_cnt_q;
   logic [3:0]  nzcv4_q;
   logic        br_valid4_q;
   logic        br_taken4_q;
   logic [3:0]  taken_cnt4_q;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [3:0]  m_nzcv;
   int          m_cnt16;
   int          m_cnt4;
   logic        exp_valid;
   logic        exp_taken;
   logic [1:0]  exp_q[$];

   cond_branch_unit #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
      .ex_nzcv(ex_nzcv), .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush),
      .id_br_type(id_br_type), .id_cond(id_cond), .id_reg_val(id_reg_val),
      .nzcv_q(nzcv_q), .br_valid_q(br_valid_q), .br_taken_q(br_taken_q),
      .taken_cnt_q(taken_cnt_q)
   );

   cond_branch_unit #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
      .ex_nzcv(ex_nzcv), .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush),
      .id_br_type(id_br_type), .id_cond(id_cond), .id_reg_val(id_reg_val),
      .nzcv_q(nzcv4_q), .br_valid_q(br_valid4_q), .br_taken_q(br_taken4_q),
      .taken_cnt_q(taken_cnt4_q)
   );

   always #5 clk = ~clk;

   // ARM encoding: bits [3:1] pick a base test, bit 0 inverts it (except AL).
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0:    r = z;
         3'd1:    r = cf;
         3'd2:    r = n;
         3'd3:    r = v;
         3'd4:    r = cf && !z;
         3'd5:    r = (n == v);
         3'd6:    r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (c[0] && c[3:1] != 3'd7) r = !r;
      return r;
   endfunction

   // predict the next edge from current inputs, then advance one clock
   task automatic model_edge();
      logic [3:0] f;
      logic       iss;
      logic       tk;
      f   = (ex_valid && ex_set_flags) ? ex_nzcv : m_nzcv;
      iss = id_valid && !id_stall && !id_flush && (id_br_type != 2'b00);
      case (id_br_type)
         2'b01:   tk = cond_holds(id_cond, f);
         2'b10:   tk = (id_reg_val == 64'd0);
         2'b11:   tk = (id_reg_val != 64'd0);
         default: tk = 1'b0;
      endcase
      tk = tk && iss;
      if (reset) begin
         m_nzcv = 4'd0; m_cnt16 = 0; m_cnt4 = 0; exp_valid = 1'b0; exp_taken = 1'b0;
      end else begin
         if (ex_valid && ex_set_flags) m_nzcv = ex_nzcv;
         exp_valid = iss;
         exp_taken = tk;
         if (tk && m_cnt16 < 65535) m_cnt16++;
         if (tk && m_cnt4 < 15) m_cnt4++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_set_flags = 0; ex_nzcv = 0;
      id_valid = 0; id_stall = 0; id_flush = 0; id_br_type = 0; id_cond = 0; id_reg_val = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      m_nzcv = 4'hA; m_cnt16 = 99; m_cnt4 = 9;
      repeat (2) model_edge();
      reset = 0;
      model_edge();
      n_cmp++; if (nzcv_q !== 4'd0) begin n_err++; $display("FAIL reset_nzcv: got %h want 0", nzcv_q); end
      n_cmp++; if (br_valid_q !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", br_valid_q); end
      n_cmp++; if (br_taken_q !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", br_taken_q); end
      n_cmp++; if (taken_cnt_q !== 16'd0 || taken_cnt4_q !== 4'd0) begin
         n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", taken_cnt_q, taken_cnt4_q); end
   endtask

   task automatic test_forward();
      idle_inputs();
      ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'b0100;
      id_valid = 1; id_br_type = 2'b01; id_cond = 4'b0000;
      model_edge();
      n_cmp++; if (br_valid_q !== 1'b1 || br_taken_q !== 1'b1) begin
         n_err++; $display("FAIL fwd_eq: got v=%b t=%b want v=1 t=1", br_valid_q, br_taken_q); end
      n_cmp++; if (nzcv_q !== 4'b0100) begin n_err++; $display("FAIL fwd_nzcv: got %h want 4", nzcv_q); end
      id_cond = 4'b0001;
      model_edge();
      n_cmp++; if (br_valid_q !== 1'b1 || br_taken_q !== 1'b0) begin
         n_err++; $display("FAIL fwd_ne: got v=%b t=%b want v=1 t=0", br_valid_q, br_taken_q); end
      // stale register flags must not be seen when EX writes new ones
      ex_nzcv = 4'b0000; id_cond = 4'b0000;
      model_edge();
      n_cmp++; if (br_taken_q !== 1'b0) begin n_err++; $display("FAIL fwd_override: got t=%b want 0", br_taken_q); end
   endtask

   task automatic test_cond_sweep();
      logic [3:0] dcond [4] = '{4'b1011, 4'b1010, 4'b1101, 4'b1100};
      logic       dexp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      idle_inputs();
      ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'b1000;
      model_edge();
      ex_set_flags = 0; ex_nzcv = 4'b0111;
      id_valid = 1; id_br_type = 2'b01;
      for (int i = 0; i < 4; i++) begin
         id_cond = dcond[i];
         model_edge();
         n_cmp++; if (br_valid_q !== 1'b1 || br_taken_q !== dexp[i]) begin
            n_err++; $display("FAIL cond_n1v0 cond=%b: got v=%b t=%b want v=1 t=%b", dcond[i], br_valid_q, br_taken_q, dexp[i]); end
      end
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            if ($urandom_range(0, 1) == 1) begin
               ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'(f);
            end else begin
               idle_inputs();
               ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'(f);
               model_edge();
               ex_valid = 1'($urandom_range(0, 1)); ex_set_flags = 0; ex_nzcv = 4'($urandom);
            end
            id_valid = 1; id_stall = 0; id_flush = 0; id_br_type = 2'b01; id_cond = 4'(c);
            model_edge();
            n_cmp++; if (br_valid_q !== exp_valid || br_taken_q !== exp_taken || nzcv_q !== m_nzcv) begin
               n_err++; $display("FAIL sweep f=%h c=%h: got v=%b t=%b nzcv=%h want v=%b t=%b nzcv=%h",
                  f, c, br_valid_q, br_taken_q, nzcv_q, exp_valid, exp_taken, m_nzcv); end
         end
      end
   endtask

   task automatic test_cbz();
      logic [1:0]  btype [4] = '{2'b10, 2'b10, 2'b11, 2'b10};
      logic [63:0] rval  [4] = '{64'h0, 64'h8000_0000_0000_0000, 64'h1, 64'h5};
      logic        dexp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      idle_inputs();
      id_valid = 1; id_cond = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         id_br_type = btype[i]; id_reg_val = rval[i];
         // last vector: Z=1 forwarded from EX must not influence CBZ
         ex_valid = (i == 3); ex_set_flags = (i == 3); ex_nzcv = 4'b0100;
         model_edge();
         n_cmp++; if (br_valid_q !== 1'b1 || br_taken_q !== dexp[i]) begin
            n_err++; $display("FAIL cbz_dir%0d: got v=%b t=%b want v=1 t=%b", i, br_valid_q, br_taken_q, dexp[i]); end
      end
      for (int i = 0; i < 40; i++) begin
         id_br_type = 2'($urandom_range(2, 3));
         id_reg_val = ($urandom_range(0, 2) == 0) ? 64'd0 : (64'd1 << $urandom_range(0, 63));
         ex_valid = 1; ex_set_flags = 1'($urandom); ex_nzcv = 4'($urandom); id_cond = 4'($urandom);
         model_edge();
         n_cmp++; if (br_valid_q !== exp_valid || br_taken_q !== exp_taken) begin
            n_err++; $display("FAIL cbz_rand%0d: got v=%b t=%b want v=%b t=%b", i, br_valid_q, br_taken_q, exp_valid, exp_taken); end
      end
   endtask

   task automatic test_flush_stall();
      idle_inputs();
      id_valid = 1; id_br_type = 2'b01; id_cond = 4'b1110;
      id_flush = 1;
      model_edge();
      n_cmp++; if (br_valid_q !== 1'b0 || br_taken_q !== 1'b0) begin
         n_err++; $display("FAIL flush: got v=%b t=%b want 0 0", br_valid_q, br_taken_q); end
      id_flush = 0; id_stall = 1;
      ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'b1010;
      model_edge();
      n_cmp++; if (br_valid_q !== 1'b0 || nzcv_q !== 4'b1010) begin
         n_err++; $display("FAIL stall: got v=%b nzcv=%h want v=0 nzcv=a", br_valid_q, nzcv_q); end
      id_flush = 1; ex_nzcv = 4'b0011;
      model_edge();
      n_cmp++; if (br_valid_q !== 1'b0 || nzcv_q !== 4'b0011) begin
         n_err++; $display("FAIL flush_stall: got v=%b nzcv=%h want v=0 nzcv=3", br_valid_q, nzcv_q); end
      id_flush = 0; id_stall = 0; ex_valid = 0;
      for (int i = 0; i < 16; i++) begin
         id_br_type = 2'b00; id_cond = 4'(i); id_valid = 1;
         model_edge();
         n_cmp++; if (br_valid_q !== 1'b0 || br_taken_q !== 1'b0) begin
            n_err++; $display("FAIL none_type cond=%h: got v=%b t=%b want 0 0", i, br_valid_q, br_taken_q); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] got;
      logic [1:0] want;
      idle_inputs();
      id_valid = 1; id_br_type = 2'b01; id_cond = 4'b1110;
      for (int i = 0; i < 17; i++) begin
         model_edge();
         exp_q.push_back({exp_valid, exp_taken});
         want = exp_q.pop_front();
         got = {br_valid_q, br_taken_q};
         n_cmp++; if (got !== want) begin n_err++; $display("FAIL b2b%0d: got %b want %b", i, got, want); end
      end
      n_cmp++; if (taken_cnt4_q !== 4'hF) begin n_err++; $display("FAIL sat4: got %h want f", taken_cnt4_q); end
      n_cmp++; if (taken_cnt_q !== 16'(m_cnt16)) begin n_err++; $display("FAIL cnt16: got %0d want %0d", taken_cnt_q, m_cnt16); end
      for (int i = 0; i < 200; i++) begin
         ex_valid = 1'($urandom); ex_set_flags = 1'($urandom); ex_nzcv = 4'($urandom);
         id_valid = ($urandom_range(0, 7) != 0); id_stall = ($urandom_range(0, 5) == 0);
         id_flush = ($urandom_range(0, 5) == 0); id_br_type = 2'($urandom); id_cond = 4'($urandom);
         id_reg_val = ($urandom_range(0, 1) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
         model_edge();
         exp_q.push_back({exp_valid, exp_taken});
         want = exp_q.pop_front();
         got = {br_valid_q, br_taken_q};
         n_cmp++; if (got !== want || nzcv_q !== m_nzcv || taken_cnt_q !== 16'(m_cnt16) || taken_cnt4_q !== 4'(m_cnt4)) begin
            n_err++; $display("FAIL rand%0d: got vt=%b nzcv=%h cnt=%0d/%0d want vt=%b nzcv=%h cnt=%0d/%0d",
               i, got, nzcv_q, taken_cnt_q, taken_cnt4_q, want, m_nzcv, m_cnt16, m_cnt4); end
      end
      id_valid = 1; id_stall = 0; id_flush = 0; id_br_type = 2'b01; id_cond = 4'b1110;
      ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'b1111;
      repeat (3) model_edge();
      reset = 1;
      model_edge();
      n_cmp++; if (nzcv_q !== 4'd0 || br_valid_q !== 1'b0 || br_taken_q !== 1'b0 || taken_cnt_q !== 16'd0 || taken_cnt4_q !== 4'd0) begin
         n_err++; $display("FAIL mid_reset: got nzcv=%h v=%b t=%b cnt=%h/%h want all 0",
            nzcv_q, br_valid_q, br_taken_q, taken_cnt_q, taken_cnt4_q); end
      reset = 0;
      model_edge();
      n_cmp++; if (br_taken_q !== 1'b1 || taken_cnt_q !== 16'd1 || nzcv_q !== 4'hF) begin
         n_err++; $display("FAIL post_reset: got t=%b cnt=%0d nzcv=%h want t=1 cnt=1 nzcv=f", br_taken_q, taken_cnt_q, nzcv_q); end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_forward();
      test_cond_sweep();
      test_cbz();
      test_flush_stall();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
